// File: rtl/display_plotter.sv
// display_plotter: snapshots a 16x32 display vector on start and scans it column-major, one VGA write per clock.
//
// Ports:
//    i_clock    system clock
//    i_reset    synchronous active-high reset; abandons any scan in progress
//    i_start    request a frame scan, sampled only while idle
//    i_hold     stall the scan: counters freeze, plot forced low
//    i_display  pixel (x,y) = i_display[HEIGHT*x + y]
//    o_busy     high from the accepting edge through the done cycle
//    o_done     one-cycle pulse after the last pixel is emitted
//    o_x/o_y    pixel coordinate to vga_adapter
//    o_colour   pixel colour to vga_adapter
//    o_plot     write strobe to vga_adapter
//
// Build option DISPLAY_PLOTTER_DIFF_PLOT_EN: remember the last drawn frame and
// strobe plot only for pixels that changed since then.
module display_plotter #(
   parameter int         X_BITS     = 4,
   parameter int         Y_BITS     = 5,
   parameter logic [2:0] COLOUR_ON  = 3'b111,
   parameter logic [2:0] COLOUR_OFF = 3'b000
) (
   input  logic                              i_clock,
   input  logic                              i_reset,
   input  logic                              i_start,
   input  logic                              i_hold,
   input  logic [2**(X_BITS+Y_BITS)-1:0]     i_display,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [X_BITS-1:0]                 o_x,
   output logic [Y_BITS-1:0]                 o_y,
   output logic [2:0]                        o_colour,
   output logic                              o_plot
);
   localparam int NPIX = 2**(X_BITS+Y_BITS);
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(2**X_BITS - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(2**Y_BITS - 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]               r_state;
   logic [NPIX-1:0]          r_snap;
   logic [X_BITS-1:0]        r_cx;
   logic [Y_BITS-1:0]        r_cy;
   logic [X_BITS+Y_BITS-1:0] w_idx;
   logic                     w_last;
   logic                     w_plot;

   // HEIGHT is a power of two, so HEIGHT*cx+cy is just the concatenation.
   assign w_idx  = {r_cx, r_cy};
   assign w_last = (r_cx == X_LAST) && (r_cy == Y_LAST);

`ifdef DISPLAY_PLOTTER_DIFF_PLOT_EN
   logic [NPIX-1:0] r_prev;
   assign w_plot = r_snap[w_idx] != r_prev[w_idx];
   // Cleared on reset to match the black background, so every set pixel is redrawn.
   always_ff @(posedge i_clock)
      if (i_reset)
         r_prev <= '0;
      else if (r_state == S_SCAN && !i_hold && w_last)
         r_prev <= r_snap;
`else
   assign w_plot = 1'b1;
`endif

   always_ff @(posedge i_clock)
      if (r_state == S_IDLE && i_start)
         r_snap <= i_display;

   always_ff @(posedge i_clock)
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_cx     <= '0;
         r_cy     <= '0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_x      <= '0;
         o_y      <= '0;
         o_colour <= COLOUR_OFF;
         o_plot   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_plot <= 1'b0;
               o_done <= 1'b0;
               if (i_start) begin
                  r_cx    <= '0;
                  r_cy    <= '0;
                  o_busy  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (i_hold)
                  o_plot <= 1'b0;
               else begin
                  o_x      <= r_cx;
                  o_y      <= r_cy;
                  o_colour <= r_snap[w_idx] ? COLOUR_ON : COLOUR_OFF;
                  o_plot   <= w_plot;
                  r_cy     <= r_cy + 1'b1;
                  if (r_cy == Y_LAST)
                     r_cx <= r_cx + 1'b1;
                  if (w_last)
                     r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // First DONE cycle raises done; the second drops busy and returns to
               // idle, so a start seen on that edge is deliberately not accepted.
               o_plot <= 1'b0;
               if (!o_done)
                  o_done <= 1'b1;
               else begin
                  o_done  <= 1'b0;
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_display_plotter.sv
// tb_display_plotter: randomized frame scans checked against a pixel-list reference model.
module tb_display_plotter;
   localparam int XB = 4;
   localparam int YB = 5;
   localparam int H  = 32;
   localparam int N  = 512;

   logic          clk = 1'b0;
   logic          rst, start, hold;
   logic [N-1:0]  disp;
   logic          o_busy, o_done, o_plot;
   logic [XB-1:0] o_x;
   logic [YB-1:0] o_y;
   logic [2:0]    o_colour;
   logic [N-1:0]  prev_m = '0;
   logic [N-1:0]  d;
   int            n_total = 0;
   int            n_bad = 0;

   display_plotter dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_hold(hold), .i_display(disp),
      .o_busy(o_busy), .o_done(o_done), .o_x(o_x), .o_y(o_y), .o_colour(o_colour), .o_plot(o_plot)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] rand_disp();
      logic [N-1:0] v;
      for (int i = 0; i < N; i += 32) v[i +: 32] = $urandom;
      return v;
   endfunction

   // The expected frame is the list of pixels 0..N-1 in column-major order;
   // a non-held cycle emits the next one, a held cycle repeats nothing.
   task automatic frame(input logic [N-1:0] fd, input bit pre, input int hold_after, input int hold_len,
                        input bit rand_hold, input bit poke, input int abort_at, input bit chain);
      logic [N-1:0] snap;
      int emitted, hdone, cyc, lx, ly, lc;
      bit h, poked;
      emitted = 0; hdone = 0; cyc = 0; lx = 0; ly = 0; lc = 0; poked = 0;
      snap = fd;
      if (!pre) begin
         disp = fd;
         start = 1;
         tick;
         start = 0;
         check("accept_busy", 32'(o_busy), 1);
         check("accept_plot", 32'(o_plot), 0);
      end
      while (emitted < N && cyc < 2000) begin
         if (emitted == hold_after && hdone < hold_len) begin
            h = 1;
            hdone++;
         end else
            h = rand_hold && ($urandom_range(0, 7) == 0);
         hold = h;
         if (poke && emitted == 200 && !poked) begin
            poked = 1;
            start = 1;
            disp = rand_disp();
         end
         if (abort_at >= 0 && emitted == abort_at) begin
            rst = 1;
            tick;
            rst = 0;
            hold = 0;
            check("abort_plot", 32'(o_plot), 0);
            check("abort_busy", 32'(o_busy), 0);
            check("abort_done", 32'(o_done), 0);
            check("abort_x", 32'(o_x), 0);
            check("abort_y", 32'(o_y), 0);
            check("abort_colour", 32'(o_colour), 0);
            prev_m = '0;
            return;
         end
         tick;
         start = 0;
         cyc++;
         check("scan_busy", 32'(o_busy), 1);
         check("scan_done", 32'(o_done), 0);
         if (h) begin
            check("hold_plot", 32'(o_plot), 0);
            check("hold_x", 32'(o_x), 32'(lx));
            check("hold_y", 32'(o_y), 32'(ly));
            check("hold_colour", 32'(o_colour), 32'(lc));
         end else begin
            lx = emitted / H;
            ly = emitted % H;
            lc = snap[emitted] ? 7 : 0;
            check("pix_x", 32'(o_x), 32'(lx));
            check("pix_y", 32'(o_y), 32'(ly));
            check("pix_colour", 32'(o_colour), 32'(lc));
`ifdef DISPLAY_PLOTTER_DIFF_PLOT_EN
            check("pix_plot", 32'(o_plot), 32'(snap[emitted] != prev_m[emitted]));
`else
            check("pix_plot", 32'(o_plot), 1);
`endif
            emitted++;
         end
      end
      check("scan_complete", 32'(emitted), N);
      hold = 1'($urandom);
      tick;
      check("done_pulse", 32'(o_done), 1);
      check("done_busy", 32'(o_busy), 1);
      check("done_plot", 32'(o_plot), 0);
      prev_m = snap;
      if (chain) start = 1;
      hold = 1'($urandom);
      tick;
      check("end_done", 32'(o_done), 0);
      check("end_busy", 32'(o_busy), 0);
      check("end_plot", 32'(o_plot), 0);
      hold = 0;
      if (!chain) begin
         tick;
         check("idle_busy", 32'(o_busy), 0);
         check("idle_plot", 32'(o_plot), 0);
      end
   endtask

   initial begin
      rst = 1; start = 0; hold = 0; disp = '0;
      tick;
      tick;
      check("rst_busy", 32'(o_busy), 0);
      check("rst_done", 32'(o_done), 0);
      check("rst_plot", 32'(o_plot), 0);
      check("rst_x", 32'(o_x), 0);
      check("rst_y", 32'(o_y), 0);
      check("rst_colour", 32'(o_colour), 0);
      rst = 0;
      tick;
      check("idle_no_start", 32'(o_busy), 0);
      frame('0, 0, -1, 0, 0, 0, -1, 0);
      d = '0;
      d[32*3+7] = 1'b1;
      frame(d, 0, -1, 0, 0, 0, -1, 0);
      frame(rand_disp(), 0, 96, 5, 0, 0, -1, 0);
      frame(rand_disp(), 0, -1, 0, 1, 1, -1, 0);
      frame(rand_disp(), 0, -1, 0, 1, 0, 100, 0);
      frame(rand_disp(), 0, -1, 0, 0, 0, -1, 0);
      d = rand_disp();
      frame(d, 0, -1, 0, 1, 0, -1, 1);
      tick;
      check("chain_accept", 32'(o_busy), 1);
      start = 0;
      frame(d, 1, -1, 0, 1, 0, -1, 0);
      rst = 1;
      tick;
      rst = 0;
      prev_m = '0;
      d = '0;
      d[32*5+5] = 1'b1;
      frame(d, 0, -1, 0, 0, 0, -1, 0);
      frame(d, 0, -1, 0, 0, 0, -1, 0);
      frame('0, 0, -1, 0, 1, 0, -1, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/display_plotter.md
Name: display_plotter

Overview:
- Downstream of game_state. On a start pulse it snapshots the 16x32 display vector.
- Walks every pixel in column-major order and emits one VGA write per clock (x, y, colour, plot) into vga_adapter at RESOLUTION "16x32".
- Replaces the free-running x/y counters in datapath with a bounded, stallable frame scan that reports busy/done.

Parameters:
- X_BITS, 4, x coordinate width; WIDTH = 2**X_BITS columns
- Y_BITS, 5, y coordinate width; HEIGHT = 2**Y_BITS rows
- COLOUR_ON, 3'b111, colour driven for a set pixel
- COLOUR_OFF, 3'b000, colour driven for a clear pixel

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- start  in  1  request a frame scan; sampled only in IDLE
- hold  in  1  stall the scan; freezes counters, forces plot low
- display  in  WIDTH*HEIGHT  pixel (x,y) = display[HEIGHT*x + y]
- busy  out  1  high from the edge that accepts start through the done cycle
- done  out  1  one-cycle pulse after the last pixel is emitted
- x  out  X_BITS  pixel column to vga_adapter
- y  out  Y_BITS  pixel row to vga_adapter
- colour  out  3  pixel colour to vga_adapter
- plot  out  1  write strobe to vga_adapter

Behaviour:
- Reset (synchronous, active-high) returns to IDLE with x=0, y=0, colour=COLOUR_OFF, plot=0, busy=0, done=0, and internal counters cleared. This applies mid-scan; the partial frame is abandoned.
- All outputs are registered.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge k: snapshot <= display, cx=0, cy=0, state <= SCAN, busy=1 from edge k.
  - start=0: outputs hold, plot=0.
- SCAN, each edge with hold=0:
  - x<=cx, y<=cy, colour <= snapshot[HEIGHT*cx+cy] ? COLOUR_ON : COLOUR_OFF, plot<=1.
  - Then cy++. On cy==HEIGHT-1, cy wraps to 0 and cx++.
  - After emitting (WIDTH-1, HEIGHT-1): state <= DONE.
- SCAN, edge with hold=1: plot<=0; x, y, colour, cx, cy are unchanged. On hold release, the scan resumes at the next unemitted pixel; no pixel is skipped or duplicated.
- First plot is at edge k+1. With no hold, plot is high for exactly WIDTH*HEIGHT (512) consecutive cycles, edges k+1..k+512.
- DONE: plot<=0, done<=1 for one cycle, busy stays 1. Next edge: IDLE, busy<=0, done<=0.
- start while busy: ignored, not queued.
- start at the edge DONE->IDLE: ignored. It is accepted on the following edge if still high.
- display changes during SCAN: no effect; only the snapshot is drawn.
- hold in IDLE or DONE: no effect.
- Counter arithmetic: cx and cy are exactly X_BITS/Y_BITS wide; wrap is natural modulo. Scan-end detection uses the explicit (WIDTH-1, HEIGHT-1) compare, not overflow.

Optional Feature:
- Macro: DISPLAY_PLOTTER_DIFF_PLOT_EN
- Defined:
  - Adds a WIDTH*HEIGHT "prev" register, reset to all zeros to match the black.mif background.
  - In SCAN, plot<=1 only when snapshot bit != prev bit; x, y and colour still update every non-held cycle.
  - The scan still takes 512 cycles.
  - On entering DONE, prev <= snapshot.
  - Reset mid-scan clears prev, so the next frame redraws all set pixels.
- Undefined: no prev register; every pixel is plotted every frame.

Test Plan:
- Reset, display=0, start=1 for 1 cycle -> busy rises at accept edge. 512 plot cycles, all colour=000, in order (0,0),(0,1)..(0,31),(1,0)..(15,31). done pulses once at cycle 513 after accept; busy falls the cycle after done.
- display has bit 32*3+7 set only -> exactly one plot with colour=111, at x=3, y=7 (the 104th plot); all others 000.
- hold=1 for 5 cycles after plot of (2,31) -> plot=0 for those 5 cycles with x=2, y=31 held; next plot is (3,0). Total plots=512, done 5 cycles later than baseline.
- start pulsed again at plot #200 and display changed mid-scan -> ignored. Emitted colours match the snapshot; no second scan starts.
- reset=1 at plot #100 -> next cycle plot=0, busy=0, x=0, y=0. A new start restarts at (0,0).
- DIFF_PLOT_EN: frame1 bit (5,5) set -> 1 plot. Frame2 same display -> 0 plots, done still at cycle 513. Frame3 bit cleared -> 1 plot at (5,5), colour 000.
